jtcps1_gfx_arbiter: RTL and testbench

- Shares the single CPS1 graphics ROM port among four layer fetchers: OBJ, SCROLL1, SCROLL2 and SCROLL3.
- For each granted request it drives the existing GFX bank mapper (layer + code bits), waits for the registered bank decode, then applies the returned offset/mask to form the ROM address.
- Runs the ROM handshake and returns data to the winner.
- Sits between the tile/object engines and the SDRAM GFX slot.

---
 rtl/jtcps1_gfx_pkg.sv | 18 +
 rtl/jtcps1_rr_pick.sv | 24 ++
 rtl/jtcps1_gfx_arbiter.sv | 123 ++++++++++++
 tb/tb_jtcps1_gfx_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/jtcps1_gfx_pkg.sv
// Shared constants for the CPS1 GFX ROM arbiter: layer codes, FSM encoding, requester count.
package jtcps1_gfx_pkg;

  localparam int NREQ = 4;

  localparam logic [2:0] LAYER_OBJ  = 3'd0;
  localparam logic [2:0] LAYER_SCR1 = 3'd1;
  localparam logic [2:0] LAYER_SCR2 = 3'd2;
  localparam logic [2:0] LAYER_SCR3 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAP  = 2'd1,
    ST_XLAT = 2'd2,
    ST_ROM  = 2'd3
  } gfx_state_t;

endpackage

// File: rtl/jtcps1_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above pointer, wrapping 3->0.
module jtcps1_rr_pick
  import jtcps1_gfx_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      pointer,
  output logic            any,
  output logic [1:0]      idx
);

  logic [1:0] pos;

  // Walk from the farthest slot back to the pointer so the nearest hit is written last.
  always_comb begin
    any = |req;
    idx = 2'd0;
    pos = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = pointer + 2'(k);
      if (req[pos]) idx = pos;
    end
  end

endmodule

// File: rtl/jtcps1_gfx_arbiter.sv
// Shares the CPS1 GFX ROM port among OBJ/SCR1/SCR2/SCR3 via the bank mapper.
// Optional macro JTCPS1_GFXARB_OBJPRIO_EN: OBJ always wins, scroll layers rotate among themselves.
module jtcps1_gfx_arbiter
  import jtcps1_gfx_pkg::*;
#(
  parameter int AW = 20,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   ok,
  output logic [DW-1:0]     data,
  output logic              map_en,
  output logic [2:0]        map_layer,
  output logic [9:0]        map_cin,
  input  logic [3:0]        map_offset,
  input  logic [3:0]        map_mask,
  output logic              rom_cs,
  output logic [AW-1:0]     rom_addr,
  input  logic              rom_ok,
  input  logic [DW-1:0]     rom_data,
  output logic              busy
);

  gfx_state_t state, state_nxt;
  logic [1:0]    ptr;
  logic [1:0]    win;
  logic [AW-1:0] a;
  logic          pick_any;
  logic [1:0]    pick_idx;
  logic [AW-1:0] sel_addr;

`ifdef JTCPS1_GFXARB_OBJPRIO_EN
  logic       scr_any;
  logic [1:0] scr_idx;

  jtcps1_rr_pick u_pick (
    .req     ({req[3:1], 1'b0}),
    .pointer (ptr),
    .any     (scr_any),
    .idx     (scr_idx)
  );

  assign pick_any = req[0] | scr_any;
  assign pick_idx = req[0] ? 2'd0 : scr_idx;
`else
  jtcps1_rr_pick u_pick (
    .req     (req),
    .pointer (ptr),
    .any     (pick_any),
    .idx     (pick_idx)
  );
`endif

  assign sel_addr = addr[int'(pick_idx)*AW +: AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    map_en    = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (pick_any) state_nxt = ST_MAP;
      end
      ST_MAP: begin
        map_en    = 1'b1;
        state_nxt = ST_XLAT;
      end
      ST_XLAT: state_nxt = ST_ROM;
      ST_ROM:  if (rom_ok) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok        <= '0;
      data      <= '0;
      map_layer <= LAYER_OBJ;
      map_cin   <= '0;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      ptr       <= 2'd0;
      win       <= 2'd0;
      a         <= '0;
    end else begin
      ok <= '0;
      case (state)
        ST_IDLE: if (pick_any) begin
          win       <= pick_idx;
          a         <= sel_addr;
          map_layer <= {1'b0, pick_idx};
          map_cin   <= sel_addr[AW-1:AW-10];
        end
        // Mapper bank is registered at the end of MAP, so offset/mask are valid here.
        ST_XLAT: begin
          rom_addr <= {map_offset | (a[AW-1:AW-4] & map_mask), a[AW-5:0]};
          rom_cs   <= 1'b1;
        end
        ST_ROM: if (rom_ok) begin
          data   <= rom_data;
          ok     <= 4'b0001 << win;
          rom_cs <= 1'b0;
`ifdef JTCPS1_GFXARB_OBJPRIO_EN
          if (win != 2'd0) ptr <= win + 2'd1;
`else
          ptr <= win + 2'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcps1_gfx_arbiter.sv
// Directed bench for jtcps1_gfx_arbiter: translation, latency, rotation, stall and reset abort.
module tb_jtcps1_gfx_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*AW-1:0] addr;
  logic [3:0]      ok;
  logic [DW-1:0]   data;
  logic            map_en;
  logic [2:0]      map_layer;
  logic [9:0]      map_cin;
  logic [3:0]      map_offset;
  logic [3:0]      map_mask;
  logic            rom_cs;
  logic [AW-1:0]   rom_addr;
  logic            rom_ok;
  logic [DW-1:0]   rom_data;
  logic            busy;

  int n_assert = 0;
  int n_fail   = 0;

  jtcps1_gfx_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .addr       (addr),
    .ok         (ok),
    .data       (data),
    .map_en     (map_en),
    .map_layer  (map_layer),
    .map_cin    (map_cin),
    .map_offset (map_offset),
    .map_mask   (map_mask),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_ok     (rom_ok),
    .rom_data   (rom_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one grant: waits for rom_cs, delays rom_ok by lat cycles, checks the ok pulse.
  task automatic xact(input int lat, input logic [3:0] exp_ok, input logic [DW-1:0] exp_data,
                      input logic [3:0] req_after, input string tag);
    int n;
    n = 0;
    rom_ok = 1'b0;
    while (!rom_cs && n < 50) begin step(); n++; end
    repeat (lat) begin step(); n++; end
    rom_ok = 1'b1;
    while (ok == 4'b0 && n < 100) begin step(); n++; end
    rom_ok = 1'b0;
    check({tag, "_ok"}, 64'(ok), 64'(exp_ok));
    check({tag, "_data"}, 64'(data), 64'(exp_data));
    req = req_after;
    step();
    check({tag, "_pulse"}, 64'(ok), 64'(4'b0));
  endtask

  logic [3:0] exp_seq [5];

  initial begin
    rst = 1'b1; req = '0; addr = '0; map_offset = '0; map_mask = '0;
    rom_ok = 1'b0; rom_data = '0;
`ifdef JTCPS1_GFXARB_OBJPRIO_EN
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_ok", 64'(ok), 64'(4'b0));
    check("rst_data", 64'(data), 64'(0));
    check("rst_rom_cs", 64'(rom_cs), 64'(0));
    check("rst_rom_addr", 64'(rom_addr), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_map_en", 64'(map_en), 64'(0));
    check("rst_map_layer", 64'(map_layer), 64'(0));
    check("rst_map_cin", 64'(map_cin), 64'(0));
    rst = 1'b0;

    // Single SCR2 fetch with rom_ok tied high: 4 cycles request to ok.
    addr[2*AW +: AW] = 20'h5A123; map_offset = 4'h8; map_mask = 4'h3;
    rom_ok = 1'b1; rom_data = 32'hCAFE_F00D;
    req = 4'b0100;
    step();
    check("scr2_map_en", 64'(map_en), 64'(1));
    check("scr2_layer", 64'(map_layer), 64'(2));
    check("scr2_cin", 64'(map_cin), 64'(10'h168));
    check("scr2_busy", 64'(busy), 64'(1));
    req = 4'b0000; addr[2*AW +: AW] = 20'hFFFFF;
    step();
    check("scr2_map_en_drop", 64'(map_en), 64'(0));
    check("scr2_cs_xlat", 64'(rom_cs), 64'(0));
    step();
    check("scr2_cs", 64'(rom_cs), 64'(1));
    check("scr2_rom_addr", 64'(rom_addr), 64'(20'h9A123));
    check("scr2_ok_early", 64'(ok), 64'(4'b0));
    step();
    check("scr2_ok", 64'(ok), 64'(4'b0100));
    check("scr2_data", 64'(data), 64'(32'hCAFE_F00D));
    check("scr2_cs_drop", 64'(rom_cs), 64'(0));
    rom_data = '0;
    step();
    check("scr2_ok_pulse", 64'(ok), 64'(4'b0));
    check("scr2_data_hold", 64'(data), 64'(32'hCAFE_F00D));
    check("scr2_idle", 64'(busy), 64'(0));

    // Reset while waiting in ROM aborts the fetch with no ok.
    rom_ok = 1'b0; req = 4'b1000;
    repeat (3) step();
    check("abort_cs_before", 64'(rom_cs), 64'(1));
    req = 4'b0000;
    #2 rst = 1'b1;
    #1;
    check("abort_cs", 64'(rom_cs), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ok", 64'(ok), 64'(4'b0));
    step();
    rst = 1'b0;
    step();
    check("abort_no_ok", 64'(ok), 64'(4'b0));

    // All four requesting, identity mapping, rom_ok two cycles late.
    map_offset = 4'h0; map_mask = 4'hF;
    for (int i = 0; i < 4; i++) addr[i*AW +: AW] = 20'h11111 * (i + 1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rom_data = 32'hA000_0000 + k;
      xact(2, exp_seq[k], 32'hA000_0000 + k, (k == 4) ? 4'b0000 : 4'b1111, $sformatf("rr%0d", k));
    end

`ifdef JTCPS1_GFXARB_OBJPRIO_EN
    // OBJ grants left the scroll pointer at 0, so SCR1..SCR3 rotate in order.
    req = 4'b1110;
    rom_data = 32'hB000_0001; xact(0, 4'b0010, 32'hB000_0001, 4'b1110, "prio_s1");
    rom_data = 32'hB000_0002; xact(0, 4'b0100, 32'hB000_0002, 4'b1110, "prio_s2");
    rom_data = 32'hB000_0003; xact(0, 4'b1000, 32'hB000_0003, 4'b0000, "prio_s3");
`endif

    // ROM stall: everything facing the ROM and mapper must hold for 20 cycles.
    addr[2*AW +: AW] = 20'h3C456; map_offset = 4'h2; map_mask = 4'hC;
    rom_ok = 1'b0; req = 4'b0100;
    repeat (3) step();
    req = 4'b0000;
    check("stall_addr0", 64'(rom_addr), 64'(20'h2C456));
    map_offset = 4'h0; map_mask = 4'h0;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("stall_cs%0d", c), 64'(rom_cs), 64'(1));
      check($sformatf("stall_addr%0d", c), 64'(rom_addr), 64'(20'h2C456));
      check($sformatf("stall_layer%0d", c), 64'(map_layer), 64'(2));
      check($sformatf("stall_cin%0d", c), 64'(map_cin), 64'(10'h0F1));
      check($sformatf("stall_ok%0d", c), 64'(ok), 64'(4'b0));
    end
    rom_data = 32'h1234_5678; rom_ok = 1'b1;
    step();
    check("stall_ok", 64'(ok), 64'(4'b0100));
    check("stall_data", 64'(data), 64'(32'h1234_5678));
    rom_ok = 1'b0;
    step();
    check("stall_pulse", 64'(ok), 64'(4'b0));
    check("stall_idle", 64'(busy), 64'(0));

    // Pointer moved to 2 by a SCR1 grant; req=0011 then wraps to OBJ first.
    map_offset = 4'h0; map_mask = 4'hF;
    req = 4'b0010;
    rom_data = 32'hC000_0001; xact(0, 4'b0010, 32'hC000_0001, 4'b0011, "ptr2_s1");
    rom_data = 32'hC000_0002; xact(1, 4'b0001, 32'hC000_0002, 4'b0010, "ptr2_obj");
    rom_data = 32'hC000_0003; xact(1, 4'b0010, 32'hC000_0003, 4'b0000, "ptr2_s1b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
